br_wb_queue: RTL and testbench

- Writer-side front end for the register bank write port (WR/DW/RegEn).
- Accepts writeback requests from two producers, the ALU path and the memory/load path.
- Buffers requests in a small in-order FIFO and drains one per cycle into the bank through registered WR/DW/RegEn.
- Gives the decode stage a pending-write hazard flag per read port, plus optional forwarding of the newest pending value.

---
 rtl/br_pkg.sv | 15 +
 rtl/br_wb_match.sv | 58 +++++
 rtl/br_wb_queue.sv | 119 +++++++++++
 tb/tb_br_wb_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared constants and entry type for the writeback queue (BR_WB_FWD_EN selects forwarding)
package br_pkg;

    localparam int BR_AW   = 5;
    localparam int BR_DW_W = 32;

    localparam logic [BR_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               valid;
        logic [BR_AW-1:0]   addr;
        logic [BR_DW_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/br_wb_match.sv
// rtl/br_wb_match.sv - DEPTH-way pending-write address match, newest-first data select under BR_WB_FWD_EN
module br_wb_match
    import br_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = BR_AW,
    parameter int DW_W  = BR_DW_W
) (
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [DEPTH-1:0][AW-1:0]   addr_i,
`ifdef BR_WB_FWD_EN
    input  logic [DEPTH-1:0][DW_W-1:0] data_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
`endif
    input  logic [AW-1:0]              raddr_i,
    output logic                       hit_o,
    output logic [DW_W-1:0]            data_o
);

    logic any_match;
    logic nonzero;

    assign nonzero = (raddr_i != AW'(REG_ZERO));

    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_i[k] && (addr_i[k] == raddr_i)) begin
                any_match = 1'b1;
            end
        end
    end

    assign hit_o = any_match && nonzero;

`ifdef BR_WB_FWD_EN
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;

    // Walk slots oldest-first starting at wr_ptr so the last match is the newest.
    always_comb begin
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr_i + PW'(k);
            if (valid_i[idx] && (addr_i[idx] == raddr_i)) begin
                data_o = data_i[idx];
            end
        end
        if (!nonzero) begin
            data_o = '0;
        end
    end
`else
    assign data_o = '0;
`endif

endmodule

// File: rtl/br_wb_queue.sv
// rtl/br_wb_queue.sv - two-producer in-order writeback FIFO feeding the register bank write port
// Optional newest-value forwarding on fwd1/fwd2 is enabled by defining BR_WB_FWD_EN.
module br_wb_queue
    import br_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = BR_AW,
    parameter  int DW_W  = BR_DW_W,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_wr,
    input  logic [DW_W-1:0] mem_dw,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_wr,
    input  logic [DW_W-1:0] alu_dw,
    output logic [AW-1:0]   WR,
    output logic [DW_W-1:0] DW,
    output logic            RegEn,
    input  logic [AW-1:0]   RR1,
    input  logic [AW-1:0]   RR2,
    output logic            haz1,
    output logic            haz2,
    output logic [DW_W-1:0] fwd1,
    output logic [DW_W-1:0] fwd2,
    output logic [LW-1:0]   level
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0]   addr_q;
    logic [DEPTH-1:0][DW_W-1:0] data_q;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_slot;
    logic [LW-1:0]              level_q, level_d, free;
    logic                       mem_push, alu_push, pop;

    // Free space ignores this cycle's pop, so a full queue refuses even while draining.
    assign free      = LW'(DEPTH) - level_q;
    assign mem_ready = (free != '0);
    assign alu_ready = mem_valid ? (free >= LW'(2)) : (free != '0);

    assign mem_push = mem_valid && mem_ready && (mem_wr != AW'(REG_ZERO));
    assign alu_push = alu_valid && alu_ready && (alu_wr != AW'(REG_ZERO));
    assign pop      = (level_q != '0);
    assign level    = level_q;

    always_comb begin
        alu_slot = wr_ptr_q + PW'(mem_push);
        wr_ptr_d = alu_slot + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(mem_push) + LW'(alu_push) - LW'(pop);
        valid_d  = valid_q;
        if (pop)      valid_d[rd_ptr_q] = 1'b0;
        if (mem_push) valid_d[wr_ptr_q] = 1'b1;
        if (alu_push) valid_d[alu_slot] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            WR       <= '0;
            DW       <= '0;
            RegEn    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            RegEn    <= pop;
            if (pop) begin
                WR <= addr_q[rd_ptr_q];
                DW <= data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[wr_ptr_q] <= mem_wr;
            data_q[wr_ptr_q] <= mem_dw;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_wr;
            data_q[alu_slot] <= alu_dw;
        end
    end

    br_wb_match #(.DEPTH(DEPTH), .AW(AW), .DW_W(DW_W)) u_match1 (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
`ifdef BR_WB_FWD_EN
        .data_i   (data_q),
        .wr_ptr_i (wr_ptr_q),
`endif
        .raddr_i  (RR1),
        .hit_o    (haz1),
        .data_o   (fwd1)
    );

    br_wb_match #(.DEPTH(DEPTH), .AW(AW), .DW_W(DW_W)) u_match2 (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
`ifdef BR_WB_FWD_EN
        .data_i   (data_q),
        .wr_ptr_i (wr_ptr_q),
`endif
        .raddr_i  (RR2),
        .hit_o    (haz2),
        .data_o   (fwd2)
    );

endmodule

// File: tb/tb_br_wb_queue.sv
// tb/tb_br_wb_queue.sv - self-checking bench for br_wb_queue (BR_WB_FWD_EN aware)
module tb_br_wb_queue;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]  mem_wr, alu_wr, wr_o, rr1, rr2;
    logic [31:0] mem_dw, alu_dw, dw_o, fwd1, fwd2;
    logic        regen, haz1, haz2;
    logic [2:0]  level;

    always #5 clk = ~clk;

    br_wb_queue #(.DEPTH(4), .AW(5), .DW_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_dw(mem_dw),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wr(alu_wr), .alu_dw(alu_dw),
        .WR(wr_o), .DW(dw_o), .RegEn(regen),
        .RR1(rr1), .RR2(rr2), .haz1(haz1), .haz2(haz2),
        .fwd1(fwd1), .fwd2(fwd2), .level(level)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] mwr, input logic [31:0] mdw,
                         input logic av, input logic [4:0] awr, input logic [31:0] adw,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        mem_valid = mv; mem_wr = mwr; mem_dw = mdw;
        alu_valid = av; alu_wr = awr; alu_dw = adw;
        rr1 = r1; rr2 = r2;
        #1;
    endtask

    typedef struct {
        logic        mv;  logic [4:0] mwr; logic [31:0] mdw;
        logic        av;  logic [4:0] awr; logic [31:0] adw;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        e_mr; logic e_ar; logic e_en;
        logic [4:0]  e_wr; logic [31:0] e_dw;
        logic        e_h1; logic e_h2;
        logic [31:0] e_f1; logic [31:0] e_f2;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vecs[17];
    wb_entry_t q[$];

    initial begin
        logic [31:0] ef1, ef2, ewd;
        logic        e_en, e_mr, e_ar, eh1, eh2, mv, av;
        logic [4:0]  ewr, mwr, awr, r1, r2;
        logic [31:0] mdw, adw;
        wb_entry_t   ent;
        int          accepted, peak, lvl;

        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 3, 32'h11, 1, 3, 32'h22, 3, 5, 1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 3, 3, 1, 1, 0, 5, 32'hDEADBEEF, 1, 1, 32'h22, 32'h22, 2};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 3, 4, 1, 1, 1, 3, 32'h11, 1, 0, 32'h22, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 3, 1, 1, 1, 3, 32'h22, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 32'h55, 0, 0, 0, 0, 0, 1, 1, 0, 3, 32'h22, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 7, 32'h77, 1, 7, 32'h78, 7, 7, 1, 1, 0, 3, 32'h22, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 9, 32'h99, 1, 9, 32'h9A, 7, 9, 1, 1, 0, 3, 32'h22, 1, 0, 32'h78, 0, 2};
        vecs[10] = '{1, 10, 32'hA0, 1, 11, 32'hB0, 9, 7, 1, 0, 1, 7, 32'h77, 1, 1, 32'h9A, 32'h78, 3};
        vecs[11] = '{0, 0, 0, 1, 12, 32'hC0, 10, 11, 1, 1, 1, 7, 32'h78, 1, 0, 32'hA0, 0, 3};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 12, 7, 1, 1, 1, 9, 32'h99, 1, 0, 32'hC0, 0, 3};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 9, 12, 1, 1, 1, 9, 32'h9A, 0, 1, 0, 32'hC0, 2};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 10, 0, 1, 1, 1, 10, 32'hA0, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 12, 32'hC0, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 12, 32'hC0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        mem_valid = 0; mem_wr = 0; mem_dw = 0;
        alu_valid = 0; alu_wr = 0; alu_dw = 0;
        rr1 = 0; rr2 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_regen", regen, 0);
        chk("reset_wr", wr_o, 0);
        chk("reset_dw", dw_o, 0);
        chk("reset_level", level, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].mv, vecs[i].mwr, vecs[i].mdw, vecs[i].av, vecs[i].awr, vecs[i].adw,
                  vecs[i].r1, vecs[i].r2);
            ef1 = 32'h0; ef2 = 32'h0;
`ifdef BR_WB_FWD_EN
            ef1 = vecs[i].e_f1; ef2 = vecs[i].e_f2;
`endif
            chk($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("v%0d_regen", i), regen, vecs[i].e_en);
            chk($sformatf("v%0d_wr", i), wr_o, vecs[i].e_wr);
            chk($sformatf("v%0d_dw", i), dw_o, vecs[i].e_dw);
            chk($sformatf("v%0d_haz1", i), haz1, vecs[i].e_h1);
            chk($sformatf("v%0d_haz2", i), haz2, vecs[i].e_h2);
            chk($sformatf("v%0d_fwd1", i), fwd1, ef1);
            chk($sformatf("v%0d_fwd2", i), fwd2, ef2);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
        end

        // Random scoreboard: 1000 accepted requests, then drain.
        e_en = 0; ewr = 0; ewd = 0; accepted = 0; peak = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (accepted >= 1000 && q.size() == 0 && !e_en) break;
            mv = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            av = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            mwr = 5'($urandom_range(0, 7)); awr = 5'($urandom_range(0, 7));
            mdw = $urandom; adw = $urandom;
            r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
            drive(mv, mwr, mdw, av, awr, adw, r1, r2);
            lvl  = q.size();
            if (lvl > peak) peak = lvl;
            e_mr = (4 - lvl) >= 1;
            e_ar = mv ? ((4 - lvl) >= 2) : ((4 - lvl) >= 1);
            eh1 = 0; eh2 = 0; ef1 = 0;
            foreach (q[j]) begin
                if (r1 != 0 && q[j].addr == r1) eh1 = 1;
                if (r2 != 0 && q[j].addr == r2) eh2 = 1;
            end
`ifdef BR_WB_FWD_EN
            if (r1 != 0)
                for (int j = q.size() - 1; j >= 0; j--)
                    if (q[j].addr == r1) begin ef1 = q[j].data; break; end
`endif
            chk("rnd_level", level, 3'(lvl));
            chk("rnd_mem_ready", mem_ready, e_mr);
            chk("rnd_alu_ready", alu_ready, e_ar);
            chk("rnd_haz1", haz1, eh1);
            chk("rnd_haz2", haz2, eh2);
            chk("rnd_fwd1", fwd1, ef1);
            chk("rnd_regen", regen, e_en);
            if (e_en) begin
                chk("rnd_wr", wr_o, ewr);
                chk("rnd_dw", dw_o, ewd);
            end
            e_en = (q.size() > 0);
            if (e_en) begin
                ent = q.pop_front();
                ewr = ent.addr; ewd = ent.data;
            end
            if (mv && e_mr) begin
                accepted++;
                if (mwr != 0) q.push_back('{1'b1, mwr, mdw});
            end
            if (av && e_ar) begin
                accepted++;
                if (awr != 0) q.push_back('{1'b1, awr, adw});
            end
        end
        chk("rnd_completed", (accepted >= 1000) && (q.size() == 0) && !e_en, 1);
        chk("rnd_peak_level", peak, 3);

        // Asynchronous reset with three entries pending.
        drive(1, 11, 32'h111, 1, 12, 32'h112, 0, 0);
        drive(1, 13, 32'h113, 1, 14, 32'h114, 13, 0);
        drive(0, 0, 0, 0, 0, 0, 13, 0);
        chk("pre_rst_level", level, 3);
        chk("pre_rst_regen", regen, 1);
        chk("pre_rst_wr", wr_o, 11);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_regen", regen, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_wr", wr_o, 0);
        chk("async_rst_haz1", haz1, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 13, 14);
            chk("post_rst_regen", regen, 0);
            chk("post_rst_level", level, 0);
        end

        // Pointer wrap: nine single pushes r1..r9.
        for (int k = 0; k < 11; k++) begin
            if (k < 9) drive(1, 5'(k + 1), 32'h100 + k + 1, 0, 0, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            chk("wrap_level", level, (k >= 1 && k <= 9) ? 3'd1 : 3'd0);
            chk("wrap_regen", regen, k >= 2);
            if (k >= 2) begin
                chk("wrap_wr", wr_o, 5'(k - 1));
                chk("wrap_dw", dw_o, 32'h100 + k - 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
